// File: rtl/digit_scan_mux.sv
// Multiplexed seven-segment digit scanner with a per-frame display snapshot.
// Drives a one-hot digit select and active-low anodes, and outputs the nibble for the hex decoder.
module digit_scan_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 100000,
    parameter bit LZS    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   N,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     sel,
    output logic [DIGITS-1:0]     an,
    output logic [3:0]            H,
    output logic                  dp,
    output logic                  frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] snapn;
    logic [DIGITS-1:0]   snapb;
    logic [DIGITS-1:0]   snapd;
    logic [DIGITS-1:0]   supp;
    logic [DIGITS-1:0]   dark;
    logic                tick;
    logic                last;

    assign tick = en && (cnt == CMAX);
    assign last = (idx == IMAX);

    // The snapshot reloads on the edge that wraps idx back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            snapn <= '0;
            snapb <= '1;
            snapd <= '0;
            frame <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                idx <= last ? '0 : idx + 1'b1;
                if (last) begin
                    snapn <= N;
                    snapb <= blank_in;
                    snapd <= dp_in;
                    frame <= 1'b1;
                end
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic acc;
        acc  = 1'b1;
        supp = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            acc     = acc & (snapn[4*k +: 4] == 4'd0);
            supp[k] = acc;
        end
    end

    assign dark = snapb | (LZS ? supp : '0);

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    assign an = ~(sel & ~dark);
    assign H  = snapn[{idx, 2'b00} +: 4];
    assign dp = ~(snapd[idx] & ~dark[idx]);

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux: frame-level vector table
// plus hand-written sequences for freeze, mid-frame change and reset.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] n;
    logic [3:0]  blank;
    logic [3:0]  dpi;
    logic [7:0]  n2;
    logic [1:0]  blank2;
    logic [1:0]  dpi2;

    logic [3:0] a_sel, a_an, a_h, b_sel, b_an, b_h, c_h;
    logic       a_dp, a_frame, b_dp, b_frame, c_dp, c_frame;
    logic [1:0] c_sel, c_an;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    digit_scan_mux #(.DIGITS(4), .DIV(4), .LZS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .N(n),
        .blank_in(blank), .dp_in(dpi),
        .sel(a_sel), .an(a_an), .H(a_h), .dp(a_dp), .frame(a_frame)
    );

    digit_scan_mux #(.DIGITS(4), .DIV(4), .LZS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .N(n),
        .blank_in(blank), .dp_in(dpi),
        .sel(b_sel), .an(b_an), .H(b_h), .dp(b_dp), .frame(b_frame)
    );

    digit_scan_mux #(.DIGITS(2), .DIV(1), .LZS(1'b0)) dut_c (
        .clk(clk), .reset(reset), .en(1'b1), .N(n2),
        .blank_in(blank2), .dp_in(dpi2),
        .sel(c_sel), .an(c_an), .H(c_h), .dp(c_dp), .frame(c_frame)
    );

    typedef struct {
        logic        lzs;
        logic [15:0] n;
        logic [3:0]  b;
        logic [3:0]  d;
        logic [15:0] an_exp;
        logic [15:0] h_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    vec_t vecs[7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] got,
                         input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (a_frame) return;
        end
        tests++;
        fails++;
        $display("FAIL frame_timeout got=none want=pulse");
    endtask

    initial begin
        logic [3:0] gs, ga, gh, es;
        logic       gd, gf;

        vecs[0] = '{1'b0, 16'h1234, 4'h0, 4'h0, 16'h7BDE, 16'h1234, 4'hF};
        vecs[1] = '{1'b1, 16'h0040, 4'h0, 4'h0, 16'hFFDE, 16'h0040, 4'hF};
        vecs[2] = '{1'b1, 16'h0000, 4'h0, 4'hF, 16'hFFFE, 16'h0000, 4'hE};
        vecs[3] = '{1'b0, 16'h5678, 4'h2, 4'h3, 16'h7BFE, 16'h5678, 4'hE};
        vecs[4] = '{1'b1, 16'h0300, 4'h0, 4'h4, 16'hFBDE, 16'h0300, 4'hB};
        vecs[5] = '{1'b1, 16'h5678, 4'h8, 4'h8, 16'hFBDE, 16'h5678, 4'hF};
        vecs[6] = '{1'b0, 16'h0000, 4'h0, 4'h0, 16'h7BDE, 16'h0000, 4'hF};

        reset  = 1'b1;
        en     = 1'b0;
        n      = 16'h1234;
        blank  = 4'h0;
        dpi    = 4'h0;
        n2     = 8'h9A;
        blank2 = 2'b00;
        dpi2   = 2'b01;
        cyc();
        cyc();
        check("rst_sel", 16'(a_sel), 16'h1);
        check("rst_an", 16'(a_an), 16'hF);
        check("rst_h", 16'(a_h), 16'h0);
        check("rst_dp", 16'(a_dp), 16'h1);
        check("rst_frame", 16'(a_frame), 16'h0);
        check("rst_b_an", 16'(b_an), 16'hF);

        // First frame arrives after DIGITS*DIV enabled cycles.
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check($sformatf("pre_an%0d", i), 16'(a_an), 16'hF);
            check($sformatf("pre_fr%0d", i), 16'(a_frame), 16'h0);
        end
        cyc();
        check("first_frame", 16'(a_frame), 16'h1);
        check("first_sel", 16'(a_sel), 16'h1);
        check("first_an", 16'(a_an), 16'hE);
        check("first_h", 16'(a_h), 16'h4);

        foreach (vecs[v]) begin
            n     = vecs[v].n;
            blank = vecs[v].b;
            dpi   = vecs[v].d;
            wait_frame();
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    gs = vecs[v].lzs ? b_sel : a_sel;
                    ga = vecs[v].lzs ? b_an : a_an;
                    gh = vecs[v].lzs ? b_h : a_h;
                    gd = vecs[v].lzs ? b_dp : a_dp;
                    gf = vecs[v].lzs ? b_frame : a_frame;
                    es = 4'b0001 << s;
                    check($sformatf("v%0d_s%0d_sel", v, s), 16'(gs), 16'(es));
                    check($sformatf("v%0d_s%0d_an", v, s), 16'(ga),
                          16'(vecs[v].an_exp[4*s +: 4]));
                    check($sformatf("v%0d_s%0d_h", v, s), 16'(gh),
                          16'(vecs[v].h_exp[4*s +: 4]));
                    check($sformatf("v%0d_s%0d_dp", v, s), 16'(gd),
                          16'(vecs[v].dp_exp[s]));
                    check($sformatf("v%0d_s%0d_fr", v, s), 16'(gf),
                          16'(s == 0 && c == 0));
                    cyc();
                end
            end
        end

        // Mid-frame input change stays invisible until the next frame.
        n     = 16'h1234;
        blank = 4'h0;
        dpi   = 4'h0;
        wait_frame();
        repeat (8) cyc();
        check("mid_sel", 16'(a_sel), 16'h4);
        n = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_h2_%0d", i), 16'(a_h), 16'h2);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_h1_%0d", i), 16'(a_h), 16'h1);
            check($sformatf("mid_fr_%0d", i), 16'(a_frame), 16'h0);
            cyc();
        end
        check("mid_frame", 16'(a_frame), 16'h1);
        check("mid_sel0", 16'(a_sel), 16'h1);
        check("mid_hd", 16'(a_h), 16'hD);

        // Freeze in the middle of the digit 2 slot.
        repeat (9) cyc();
        check("frz_pre_sel", 16'(a_sel), 16'h4);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("frz_sel%0d", i), 16'(a_sel), 16'h4);
            check($sformatf("frz_h%0d", i), 16'(a_h), 16'hB);
            check($sformatf("frz_an%0d", i), 16'(a_an), 16'hB);
            check($sformatf("frz_fr%0d", i), 16'(a_frame), 16'h0);
        end
        en = 1'b1;
        cyc();
        check("res_sel1", 16'(a_sel), 16'h4);
        cyc();
        check("res_sel2", 16'(a_sel), 16'h4);
        cyc();
        check("res_sel3", 16'(a_sel), 16'h8);
        check("res_h3", 16'(a_h), 16'hA);

        // One-cycle reset while digit 3 is selected.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mrst_sel", 16'(a_sel), 16'h1);
        check("mrst_an", 16'(a_an), 16'hF);
        check("mrst_fr", 16'(a_frame), 16'h0);
        check("mrst_h", 16'(a_h), 16'h0);
        check("c_rst_sel", 16'(c_sel), 16'h1);
        check("c_rst_an", 16'(c_an), 16'h3);

        // DIV=1, DIGITS=2: frame every other cycle, sel toggles each cycle.
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check($sformatf("c_sel%0d", i), 16'(c_sel),
                  (i % 2 == 1) ? 16'h2 : 16'h1);
            check($sformatf("c_fr%0d", i), 16'(c_frame),
                  16'(i % 2 == 0));
            if (i >= 2) begin
                check($sformatf("c_h%0d", i), 16'(c_h),
                      (i % 2 == 1) ? 16'h9 : 16'hA);
                check($sformatf("c_an%0d", i), 16'(c_an),
                      (i % 2 == 1) ? 16'h1 : 16'h2);
                check($sformatf("c_dp%0d", i), 16'(c_dp),
                      (i % 2 == 1) ? 16'h1 : 16'h0);
            end
        end

        // Reset on the would-be snapshot edge wins over the load.
        repeat (9) cyc();
        check("pre_ld_sel", 16'(a_sel), 16'h8);
        check("pre_ld_fr", 16'(a_frame), 16'h0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("ldrst_fr", 16'(a_frame), 16'h0);
        check("ldrst_an", 16'(a_an), 16'hF);
        check("ldrst_sel", 16'(a_sel), 16'h1);
        check("ldrst_dp", 16'(a_dp), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
